// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation sequencer.
package puf_ctrl_pkg;

    localparam int CHAL_W = 16;
    localparam logic [CHAL_W-1:0] LFSR_POLY = 16'hB400;
    localparam logic [CHAL_W-1:0] LFSR_ZERO_SUB = 16'h0001;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FIRE,
        RELAX,
        DONE
    } state_t;

    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Registered 16-bit Galois LFSR holding the current PUF challenge.
module puf_lfsr
    import puf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] value
);

    logic [CHAL_W-1:0] chal;

    // An all-zero state would lock the LFSR, so a zero seed is substituted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal <= '0;
        end else if (clr) begin
            chal <= '0;
        end else if (load) begin
            chal <= (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else if (step) begin
            chal <= lfsr_next(chal);
        end
    end

    assign value = chal;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: LFSR challenges, timed race pulses, majority vote,
// and a valid/ready response word with an unstable-bit count.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int RESP_W     = 32,
    parameter int VOTES      = 5,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        start_i,
    input  logic [CHAL_W-1:0]           seed_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [RESP_W-1:0]           resp_data_o,
    output logic [$clog2(RESP_W+1)-1:0] resp_unstable_o,
    output logic [CHAL_W-1:0]           puf_challenge_o,
    output logic                        puf_pulse_o,
    input  logic                        puf_resp_i
);

    localparam int TMAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = $clog2(RESP_W + 1);

    localparam logic [TW-1:0] T_SET = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] T_SMP = TW'(SAMPLE_CYC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VOTES - 1);
    localparam logic [VW-1:0] V_ALL = VW'(VOTES);
    localparam logic [VW-1:0] V_HALF = VW'(VOTES / 2);
    localparam logic [BW-1:0] B_LAST = BW'(RESP_W - 1);

    state_t state, state_n;

    logic [TW-1:0]     tmr, tmr_n;
    logic [VW-1:0]     vote_cnt, vote_n;
    logic [VW-1:0]     ones, ones_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [BW-1:0]     unstable, unst_n;
    logic [RESP_W-1:0] data, data_n;
    logic [1:0]        sync;
    logic              pulse_q, valid_q, busy_q;
    logic              lfsr_clr, lfsr_load, lfsr_step;
    logic              last, vbit, split;

    puf_lfsr u_lfsr (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (lfsr_clr),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed_i),
        .value (puf_challenge_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            tmr      <= '0;
            vote_cnt <= '0;
            ones     <= '0;
            bit_cnt  <= '0;
            unstable <= '0;
            data     <= '0;
            sync     <= '0;
            pulse_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            vote_cnt <= vote_n;
            ones     <= ones_n;
            bit_cnt  <= bit_n;
            unstable <= unst_n;
            data     <= data_n;
            sync     <= {sync[0], puf_resp_i};
            pulse_q  <= (state_n == FIRE);
            valid_q  <= (state_n == DONE);
            busy_q   <= (state_n != IDLE);
        end
    end

    assign last  = (tmr == '0);
    assign vbit  = (ones > V_HALF);
    assign split = (ones != '0) && (ones != V_ALL);

    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        vote_n    = vote_cnt;
        ones_n    = ones;
        bit_n     = bit_cnt;
        unst_n    = unstable;
        data_n    = data;
        lfsr_clr  = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n   = SETTLE;
                    tmr_n     = T_SET;
                    vote_n    = '0;
                    ones_n    = '0;
                    bit_n     = '0;
                    unst_n    = '0;
                    data_n    = '0;
                    lfsr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (last) begin
                    state_n = FIRE;
                    tmr_n   = T_SMP;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            FIRE: begin
                if (last) begin
                    state_n = RELAX;
                    tmr_n   = T_SET;
                    if (sync[1]) ones_n = ones + VW'(1);
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            RELAX: begin
                if (!last) begin
                    tmr_n = tmr - TW'(1);
                end else if (vote_cnt < V_LAST) begin
                    vote_n  = vote_cnt + VW'(1);
                    state_n = FIRE;
                    tmr_n   = T_SMP;
                end else begin
                    // Resolve: the challenge advances only here, pulse is low.
                    for (int i = 0; i < RESP_W; i++) begin
                        if (bit_cnt == BW'(i)) data_n[i] = vbit;
                    end
                    if (split) unst_n = unstable + BW'(1);
                    ones_n    = '0;
                    vote_n    = '0;
                    lfsr_step = 1'b1;
                    bit_n     = bit_cnt + BW'(1);
                    tmr_n     = T_SET;
                    state_n   = (bit_cnt == B_LAST) ? DONE : SETTLE;
                end
            end
            DONE: begin
                if (resp_ready_i) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort_i && (state inside {SETTLE, FIRE, RELAX})) begin
            state_n   = IDLE;
            tmr_n     = '0;
            vote_n    = '0;
            ones_n    = '0;
            bit_n     = '0;
            unst_n    = '0;
            data_n    = '0;
            lfsr_clr  = 1'b1;
            lfsr_load = 1'b0;
            lfsr_step = 1'b0;
        end
    end

    assign puf_pulse_o     = pulse_q;
    assign resp_valid_o    = valid_q;
    assign busy_o          = busy_q;
    assign resp_data_o     = data;
    assign resp_unstable_o = unstable;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a small 4-bit, 3-vote configuration.
module tb_puf_eval_ctrl;

    localparam int RESP_W = 4;
    localparam int UW = $clog2(RESP_W + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   seed;
    logic          abort;
    logic          busy;
    logic          valid;
    logic          ready;
    logic [3:0]    data;
    logic [UW-1:0] unstable;
    logic [15:0]   chal;
    logic          pulse;
    logic          puf_resp;

    int cmp = 0;
    int mis = 0;

    logic        split_mode = 1'b0;
    logic        resp_const = 1'b0;
    int          rises = 0;
    int          hi_run = 0;
    int          hi_bad = 0;
    int          viol = 0;
    logic        prev_pulse = 1'b0;
    logic [15:0] prev_chal = '0;
    logic [15:0] cap [16];

    puf_eval_ctrl #(
        .RESP_W     (4),
        .VOTES      (3),
        .SETTLE_CYC (2),
        .SAMPLE_CYC (4)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .start_i         (start),
        .seed_i          (seed),
        .abort_i         (abort),
        .busy_o          (busy),
        .resp_valid_o    (valid),
        .resp_ready_i    (ready),
        .resp_data_o     (data),
        .resp_unstable_o (unstable),
        .puf_challenge_o (chal),
        .puf_pulse_o     (pulse),
        .puf_resp_i      (puf_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF model and pulse/challenge monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!busy) begin
            rises  = 0;
            hi_run = 0;
            hi_bad = 0;
        end else begin
            if (pulse && !prev_pulse) begin
                if (rises < 16) cap[rises] = chal;
                rises++;
            end
            if (pulse) begin
                hi_run++;
            end else if (prev_pulse) begin
                if (hi_run != 4) hi_bad++;
                hi_run = 0;
            end
            if (pulse && prev_pulse && chal !== prev_chal) viol++;
        end
        prev_pulse = pulse;
        prev_chal  = chal;
        puf_resp = split_mode ? (pulse && (rises == 1 || rises == 3)) : resp_const;
    end

    task automatic start_run(input logic [15:0] s);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            cmp++;
            mis++;
            $display("FAIL %s_timeout: valid=%0b after 300 cycles, required 1", name, valid);
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            mis++;
            $display("FAIL %s_hs: valid=%0b busy=%0b, required 0 0", name, valid, busy);
        end
    endtask

    task automatic test_reset;
        cmp++;
        if ({busy, valid, pulse, data, unstable, chal} !== '0) begin
            mis++;
            $display("FAIL reset: busy=%0b valid=%0b pulse=%0b data=%h unst=%0d chal=%h, required all 0",
                     busy, valid, pulse, data, unstable, chal);
        end
    endtask

    task automatic test_stable_ones;
        int n;
        logic [15:0] exp_ch [4];
        exp_ch[0] = 16'h0001;
        exp_ch[1] = 16'hB400;
        exp_ch[2] = 16'h5A00;
        exp_ch[3] = 16'h2D00;
        split_mode = 1'b0;
        resp_const = 1'b1;
        start_run(16'h0001);
        wait_valid("ones", n);
        cmp++;
        if (n !== 80) begin
            mis++;
            $display("FAIL latency: got %0d cycles, required 80", n);
        end
        cmp++;
        if (data !== 4'hF || unstable !== '0) begin
            mis++;
            $display("FAIL ones_data: data=%h unst=%0d, required F 0", data, unstable);
        end
        for (int b = 0; b < 4; b++) begin
            cmp++;
            if (cap[3*b] !== exp_ch[b]) begin
                mis++;
                $display("FAIL chal_%0d: got %h, required %h", b, cap[3*b], exp_ch[b]);
            end
        end
        cmp++;
        if (rises !== 12 || hi_bad !== 0) begin
            mis++;
            $display("FAIL pulse_shape: rises=%0d bad_high_runs=%0d, required 12 0", rises, hi_bad);
        end
        handshake("ones");
    endtask

    task automatic test_zero_seed;
        int n;
        resp_const = 1'b0;
        start_run(16'h0000);
        cmp++;
        if (chal !== 16'h0001) begin
            mis++;
            $display("FAIL zero_seed: chal=%h, required 0001", chal);
        end
        wait_valid("zeros", n);
        cmp++;
        if (data !== 4'h0 || unstable !== '0) begin
            mis++;
            $display("FAIL zeros_data: data=%h unst=%0d, required 0 0", data, unstable);
        end
        handshake("zeros");
    endtask

    task automatic test_split_vote;
        int n;
        split_mode = 1'b1;
        start_run(16'h0001);
        wait_valid("split", n);
        split_mode = 1'b0;
        cmp++;
        if (data !== 4'h1 || unstable !== UW'(1)) begin
            mis++;
            $display("FAIL split_data: data=%h unst=%0d, required 1 1", data, unstable);
        end
    endtask

    task automatic test_hold;
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cmp++;
            if (valid !== 1'b1 || data !== 4'h1 || busy !== 1'b1) begin
                mis++;
                $display("FAIL hold_%0d: valid=%0b data=%h busy=%0b, required 1 1 1",
                         i, valid, data, busy);
            end
        end
        handshake("hold");
        start_run(16'h1234);
        cmp++;
        if (busy !== 1'b1 || chal !== 16'h1234) begin
            mis++;
            $display("FAIL restart: busy=%0b chal=%h, required 1 1234", busy, chal);
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_abort;
        int k;
        resp_const = 1'b1;
        start_run(16'h0001);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rises >= 7 && pulse) begin
                k = 1;
                break;
            end
        end
        cmp++;
        if (k == 0) begin
            mis++;
            $display("FAIL abort_reach: rises=%0d, required 7 within 300 cycles", rises);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        cmp++;
        if ({busy, valid, pulse, data, unstable, chal} !== '0) begin
            mis++;
            $display("FAIL abort: busy=%0b valid=%0b pulse=%0b data=%h unst=%0d chal=%h, required all 0",
                     busy, valid, pulse, data, unstable, chal);
        end
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (valid || busy) k = 1;
        end
        cmp++;
        if (k !== 0) begin
            mis++;
            $display("FAIL abort_quiet: valid/busy seen=%0d, required 0", k);
        end
    endtask

    task automatic test_start_abort_idle;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        seed  = 16'h00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cmp++;
        if (busy !== 1'b1 || chal !== 16'h00FF) begin
            mis++;
            $display("FAIL start_abort_idle: busy=%0b chal=%h, required 1 00FF", busy, chal);
        end
    endtask

    task automatic test_reset_mid_fire;
        int k;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pulse) begin
                k = 1;
                break;
            end
        end
        cmp++;
        if (k == 0) begin
            mis++;
            $display("FAIL rst_reach: pulse=%0b, required 1 within 50 cycles", pulse);
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp++;
        if ({busy, valid, pulse, data, unstable, chal} !== '0) begin
            mis++;
            $display("FAIL rst_async: busy=%0b valid=%0b pulse=%0b data=%h unst=%0d chal=%h, required all 0",
                     busy, valid, pulse, data, unstable, chal);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = '0;
        abort = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_stable_ones();
        test_zero_seed();
        test_split_vote();
        test_hold();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_fire();
        cmp++;
        if (viol !== 0) begin
            mis++;
            $display("FAIL chal_stable: %0d changes while pulse high, required 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
